// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: C_NUM_CTRL R/W control registers, C_NUM_STAT RO status registers.
// Optional macro REGBANK_SLVERR_EN: SLVERR on unmapped accesses and status-register writes.
module axi_lite_regbank #(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ADDR_WIDTH = 7,
  parameter int unsigned C_NUM_CTRL   = 8,
  parameter int unsigned C_NUM_STAT   = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]                S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]                S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_NUM_CTRL*C_DATA_WIDTH-1:0]     ctrl_regs,
  output logic [C_NUM_CTRL-1:0]                  ctrl_wr_pulse,
  input  logic [((C_NUM_STAT > 0) ? C_NUM_STAT : 1)*C_DATA_WIDTH-1:0] stat_regs
);

  localparam int unsigned STRB_W   = C_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned NUM_REGS = C_NUM_CTRL + C_NUM_STAT;
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_ERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t                  w_state;
  r_state_t                  r_state;
  logic                      aw_held;
  logic                      w_held;
  logic                      ar_held;
  logic [C_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [C_ADDR_WIDTH-1:0]   ar_addr_q;
  logic [C_DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic [31:0]               w_idx;
  logic [31:0]               r_idx;
  logic [C_DATA_WIDTH-1:0]   rd_data;
  logic                      wr_err;
  logic                      rd_err;
  logic                      unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, stat_regs};

  // Low address bits select bytes within a word and are dropped here.
  assign w_idx = 32'(aw_addr_q >> ADDR_LSB);
  assign r_idx = 32'(ar_addr_q >> ADDR_LSB);

`ifdef REGBANK_SLVERR_EN
  assign wr_err = (w_idx >= C_NUM_CTRL);
  assign rd_err = (r_idx >= NUM_REGS);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < C_NUM_CTRL; k++)
      if (r_idx == k) rd_data = ctrl_regs[k*C_DATA_WIDTH +: C_DATA_WIDTH];
    for (int unsigned k = 0; k < C_NUM_STAT; k++)
      if (r_idx == C_NUM_CTRL + k) rd_data = stat_regs[k*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  // Write channel: AW and W are latched independently; the commit happens once both are held.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OK;
      ctrl_regs     <= '0;
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (S_AXI_AWREADY && S_AXI_AWVALID) begin
            aw_held   <= 1'b1;
            aw_addr_q <= S_AXI_AWADDR;
          end
          if (S_AXI_WREADY && S_AXI_WVALID) begin
            w_held   <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
          end
          if (aw_held && w_held) begin
            w_state       <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= wr_err ? RESP_ERR : RESP_OK;
            for (int unsigned k = 0; k < C_NUM_CTRL; k++) begin
              if (w_idx == k) begin
                ctrl_wr_pulse[k] <= 1'b1;
                for (int unsigned b = 0; b < STRB_W; b++)
                  if (w_strb_q[b])
                    ctrl_regs[k*C_DATA_WIDTH + b*8 +: 8] <= w_data_q[b*8 +: 8];
              end
            end
          end else begin
            // Ready drops on the same edge as its handshake so a channel is never taken twice.
            S_AXI_AWREADY <= !(aw_held || (S_AXI_AWREADY && S_AXI_AWVALID));
            S_AXI_WREADY  <= !(w_held  || (S_AXI_WREADY  && S_AXI_WVALID));
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            w_state       <= W_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OK;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: the address is held for one cycle, then RDATA samples the pre-update register values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      ar_held       <= 1'b0;
      ar_addr_q     <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OK;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            ar_held       <= 1'b1;
            ar_addr_q     <= S_AXI_ARADDR;
            S_AXI_ARREADY <= 1'b0;
          end else if (ar_held) begin
            r_state      <= R_DATA;
            ar_held      <= 1'b0;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_err ? '0 : rd_data;
            S_AXI_RRESP  <= rd_err ? RESP_ERR : RESP_OK;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_state       <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OK;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axi_lite_regbank;

`ifdef REGBANK_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic [6:0]   awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [6:0]   araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [255:0] ctrl_regs;
  logic [7:0]   ctrl_wr_pulse;
  logic [127:0] stat_regs;

  logic [31:0]  ctrl_m [8];
  logic [31:0]  stat_m [4];
  int           n_cmp = 0;
  int           n_err = 0;

  assign stat_regs = {stat_m[3], stat_m[2], stat_m[1], stat_m[0]};

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .C_DATA_WIDTH (32),
    .C_ADDR_WIDTH (7),
    .C_NUM_CTRL   (8),
    .C_NUM_STAT   (4)
  ) dut (
    .ACLK          (clk),
    .ARESET        (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ctrl_regs     (ctrl_regs),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .stat_regs     (stat_regs)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_ctrl();
    for (int k = 0; k < 8; k++)
      check("ctrl_reg", ctrl_regs[k*32 +: 32], ctrl_m[k]);
  endtask

  function automatic void exp_read(input logic [6:0] addr, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr >> 2);
    if (idx < 8) begin
      d = ctrl_m[idx];
      r = 2'b00;
    end else if (idx < 12) begin
      d = stat_m[idx-8];
      r = 2'b00;
    end else begin
      d = '0;
      r = SLV ? 2'b10 : 2'b00;
    end
  endfunction

  // Presents AW and W after independent delays; returns #1 after the edge of the later handshake.
  task automatic issue_aw_w(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold);
    int idx;
    logic [31:0] mask;
    logic [7:0]  exp_pulse;
    logic [1:0]  exp_resp;
    idx = int'(addr >> 2);
    mask = '0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) mask = mask | (32'hFF << (8*b));
    if (idx < 8) begin
      ctrl_m[idx] = (ctrl_m[idx] & ~mask) | (data & mask);
      exp_pulse   = 8'(1) << idx;
      exp_resp    = 2'b00;
    end else begin
      exp_pulse = '0;
      exp_resp  = SLV ? 2'b10 : 2'b00;
    end
    issue_aw_w(addr, data, strb, aw_dly, w_dly);
    check("bvalid_early", bvalid, 1'b0);
    @(posedge clk); #1;
    check("bvalid", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    check("wr_pulse", ctrl_wr_pulse, exp_pulse);
    check_ctrl();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bvalid, 1'b1);
      check("bresp_hold", bresp, exp_resp);
      check("ready_hold", {awready, wready}, 2'b00);
      check("pulse_once", ctrl_wr_pulse, 8'h00);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clr", bvalid, 1'b0);
    check("pulse_clr", ctrl_wr_pulse, 8'h00);
  endtask

  task automatic do_read(input logic [6:0] addr, input int ar_dly, input int hold);
    bit done, hs;
    int cyc;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      arvalid = (cyc >= ar_dly);
      araddr  = addr;
      hs      = arvalid && arready;
      @(posedge clk); #1;
      if (hs) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    check("ar_handshake", done, 1'b1);
    exp_read(addr, exp_d, exp_r);
    check("rvalid_early", rvalid, 1'b0);
    @(posedge clk); #1;
    check("rvalid", rvalid, 1'b1);
    check("rdata", rdata, exp_d);
    check("rresp", rresp, exp_r);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_hold", rdata, exp_d);
      check("arready_hold", arready, 1'b0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_clr", rvalid, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp", {bresp, rresp}, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_pulse", ctrl_wr_pulse, 8'h00);
    check("rst_ctrl", ctrl_regs[63:0], 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) ctrl_m[k] = '0;
    for (int k = 0; k < 4; k++) stat_m[k] = '0;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    areset = 1'b0;

    // Sequential values to every control register, AW and W together, then read back.
    for (int k = 0; k < 8; k++)
      do_write(7'(k*4), 32'(k+1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      do_read(7'(k*4), 0, 0);

    // W leads AW by 3 cycles with a partial strobe.
    do_write(7'h08, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(7'h08, 32'hDEADBEEF, 4'b0101, 3, 0, 0);
    check("reg2_merge", ctrl_regs[95:64], 32'h11AD33EF);

    // Status read, then an attempted write to the same index.
    stat_m[0] = 32'hCAFE0001;
    do_read(7'h20, 0, 0);
    do_write(7'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(7'h20, 1, 0);

    // Unmapped read.
    do_read(7'h7C, 0, 0);

    // Back-pressure on both response channels.
    do_write(7'h14, 32'hA5A5_0F0F, 4'hF, 1, 2, 5);
    do_read(7'h14, 0, 5);

    // Reset while a write response is pending.
    issue_aw_w(7'h00, 32'h55, 4'hF, 0, 0);
    @(posedge clk); #1;
    check("pre_rst_bvalid", bvalid, 1'b1);
    check("pre_rst_reg0", ctrl_regs[31:0], 32'h55);
    areset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    areset = 1'b0;
    for (int k = 0; k < 8; k++) ctrl_m[k] = '0;
    check_ctrl();
    do_write(7'h04, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(7'h04, 0, 0);

    // Randomized mix of writes and reads over the whole address space.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        stat_m[$urandom_range(0, 3)] = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(7'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read(7'($urandom_range(0, 127)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
